serial_word_loader: RTL and testbench
=====================================

// Module: serial_word_loader
// PURPOSE
//  Upstream feeder for the load-enabled register stage. Assembles a DataWidth-bit word
//  from a qualified serial bit stream, then presents it on DOut with a one-cycle
//  active-low LD strobe so the downstream register captures it on the next falling edge.
//  Bit-gap timeout aborts a stalled frame without disturbing the downstream register.
// PARAMETERS
//  DataWidth  8  word width; bits per frame (>=2)
//  MsbFirst   1  1: first serial bit lands in DOut[DataWidth-1]; 0: in DOut[0]
//  Timeout    4  idle cycles allowed between bits in SHIFT; 0 disables timeout
// PORTS
//  Clk     in   1          clock; all state updates on falling edge
//  Reset   in   1          asynchronous, active-high reset
//  Start   in   1          begin frame; sampled only in IDLE
//  SIn     in   1          serial data bit
//  SValid  in   1          SIn qualifier; sampled only in SHIFT
//  LD      out  1          load strobe to downstream register, active low, one cycle
//  DOut    out  DataWidth  assembled word; drives downstream DIn
//  Busy    out  1          high whenever state != IDLE
//  Done    out  1          one-cycle pulse, coincident with LD low
//  Err     out  1          one-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, LD=1, DOut=0, Busy=0, Done=0, Err=0, shift
//    reg/bit count/gap timer=0. Partial frame discarded; no LD issued.
//  - All outputs registered/Moore-decoded from state; no combinational input->output path.
//  - IDLE: Start=1 -> SHIFT, clear shift reg, bit count, gap timer. SValid ignored.
//  - SHIFT: SValid=1 -> shift SIn in per MsbFirst, count++, timer=0; if it was bit
//    DataWidth-1 -> LOAD. SValid=0 -> timer++; Timeout!=0 and timer reaches Timeout-1 -> ERR.
//    Start ignored.
//  - LOAD (one cycle): DOut<=assembled word on entry, LD=0, Done=1 -> IDLE.
//  - ERR (one cycle): Err=1, LD=1, DOut unchanged -> IDLE.
//  - DOut changes only on LOAD entry or reset; held stable otherwise (incl. ERR).
//  - Latency: Start sampled edge 0, contiguous bits at edges 1..DataWidth; LD low after
//    edge DataWidth; downstream captures at edge DataWidth+1. Gaps add cycles 1:1.
//  - Start in LOAD/ERR ignored; needs fresh IDLE sample (earliest: cycle after LOAD).
//  - Bit count width $clog2(DataWidth)+1; gap timer width $clog2(Timeout)+1; no wrap.
// STRUCTURE
//  - Shared header loader_defs.vh: state encodings IDLE/SHIFT/LOAD/ERR (2-bit).
//  - Sub-module gap_timer: clear/increment counter with terminal-count flag
//    (async active-high reset); disabled when Timeout=0.
//  - Top: FSM, shift register, bit counter, DOut holding register.
// TESTING  (DataWidth=8, Timeout=4 unless stated)
//  1. MsbFirst=1, Start, bits 1,0,1,0,0,1,0,1 contiguous -> LD=0 & Done=1 one cycle after
//     8th bit edge, DOut=8'hA5, Busy 1 for 9 cycles.
//  2. Bits 1,1,0,0,0,0,0,0: MsbFirst=1 -> DOut=8'hC0; MsbFirst=0 -> DOut=8'h03.
//  3. Frame 8'h5A with 3 idle cycles between each bit -> no Err, DOut=8'h5A, LD one cycle.
//  4. After DOut=8'hA5, new frame: 3 bits then SValid=0 x4 -> Err pulse, LD stays 1,
//     DOut stays 8'hA5, Busy low next cycle.
//  5. Reset high after 5 bits of a frame -> all outputs reset values, DOut=0, no LD;
//     release, full frame 8'h3C -> DOut=8'h3C.
//  6. Start held high through frame and LOAD; SValid pulses in IDLE -> only one frame,
//     second frame starts cycle after LOAD; IDLE SValid has no effect.

Source files
------------

// File: rtl/serial_word_loader_pkg.sv
// ----------------------------------------------------------------------------
// serial_word_loader_pkg
//   Shared definitions for the serial word loader: FSM state encoding and
//   small width helpers used by the top level and the gap timer.
// ----------------------------------------------------------------------------
package serial_word_loader_pkg;

    // 2-bit FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_LOAD  = 2'b10,
        ST_ERR   = 2'b11
    } state_t;

    // Counter width able to hold 0..n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage : serial_word_loader_pkg

// File: rtl/serial_word_loader_gap_timer.sv
// ----------------------------------------------------------------------------
// serial_word_loader_gap_timer
//   Counts idle cycles between serial bits. The count is cleared by 'clear',
//   advances on 'incr' and saturates at Timeout-1, where 'tc' is raised.
//   With Timeout = 0 the timer is removed and 'tc' is tied low.
//   State updates on the falling edge of Clk.
//
// Ports
//   Clk    in  clock (falling-edge active)
//   Reset  in  asynchronous, active-high reset
//   clear  in  clear the count (priority over incr)
//   incr   in  count one idle cycle
//   tc     out count has reached Timeout-1
// ----------------------------------------------------------------------------
module serial_word_loader_gap_timer
    import serial_word_loader_pkg::*;
#(
    parameter int Timeout = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic incr,
    output logic tc
);

    localparam int CntW = cnt_width(Timeout);

    generate
        if (Timeout == 0) begin : g_disabled
            assign tc = 1'b0;
        end else begin : g_enabled
            localparam logic [CntW-1:0] TcVal = CntW'(Timeout - 1);

            logic [CntW-1:0] count;

            // Saturating at the terminal value keeps the counter from wrapping
            // even if the FSM were to sit in SHIFT past the terminal count.
            always_ff @(negedge Clk or posedge Reset) begin
                if (Reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (incr && (count != TcVal)) begin
                    count <= count + CntW'(1);
                end
            end

            assign tc = (count == TcVal);
        end
    endgenerate

endmodule : serial_word_loader_gap_timer

// File: rtl/serial_word_loader.sv
// ----------------------------------------------------------------------------
// serial_word_loader
//   Assembles a DataWidth-bit word from a qualified serial bit stream and
//   presents it on DOut with a one-cycle active-low LD strobe, so the
//   downstream load-enabled register captures it on the next falling edge.
//   A stalled frame (too many idle cycles between bits) is aborted with a
//   one-cycle Err pulse; DOut and LD are left untouched in that case.
//   All state updates on the falling edge of Clk.
//
// Ports
//   Clk     in   clock (falling-edge active)
//   Reset   in   asynchronous, active-high reset
//   Start   in   begin a frame; sampled only in IDLE
//   SIn     in   serial data bit
//   SValid  in   SIn qualifier; sampled only in SHIFT
//   LD      out  load strobe to downstream register, active low, one cycle
//   DOut    out  assembled word, drives downstream DIn
//   Busy    out  high whenever the FSM is not in IDLE
//   Done    out  one-cycle pulse coincident with LD low
//   Err     out  one-cycle pulse on timeout abort
// ----------------------------------------------------------------------------
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter bit MsbFirst  = 1'b1,
    parameter int Timeout   = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 SIn,
    input  logic                 SValid,
    output logic                 LD,
    output logic [DataWidth-1:0] DOut,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err
);

    localparam int BitCntW = cnt_width(DataWidth);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DataWidth - 1);

    state_t               state;
    state_t               state_next;
    logic [DataWidth-1:0] shreg;
    logic [DataWidth-1:0] shreg_shifted;
    logic [BitCntW-1:0]   bit_cnt;
    logic                 frame_start;
    logic                 take_bit;
    logic                 last_bit;
    logic                 gap_idle;
    logic                 gap_tc;

    assign frame_start = (state == ST_IDLE) && Start;
    assign take_bit    = (state == ST_SHIFT) && SValid;
    assign last_bit    = take_bit && (bit_cnt == LastBit);
    assign gap_idle    = (state == ST_SHIFT) && !SValid;

    // Shift register contents once the current bit is taken in.
    always_comb begin
        if (MsbFirst) begin
            shreg_shifted = {shreg[DataWidth-2:0], SIn};
        end else begin
            shreg_shifted = {SIn, shreg[DataWidth-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: assigning a default before the case guarantees every path drives
    // state_next, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (SValid) begin
                    if (bit_cnt == LastBit) begin
                        state_next = ST_LOAD;
                    end
                end else if (gap_tc) begin
                    state_next = ST_ERR;
                end
            end
            ST_LOAD:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: Moore output decode (outputs depend on the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        LD   = 1'b1;
        Done = 1'b0;
        Err  = 1'b0;
        Busy = (state != ST_IDLE);
        unique case (state)
            ST_LOAD: begin
                LD   = 1'b0;
                Done = 1'b1;
            end
            ST_ERR: begin
                Err  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register and bit counter
    // ------------------------------------------------------------------
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (frame_start) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (take_bit) begin
            shreg   <= shreg_shifted;
            bit_cnt <= bit_cnt + BitCntW'(1);
        end
    end

    // DOut only moves when the last bit arrives (i.e. on LOAD entry), so the
    // downstream register sees a stable word through ERR and IDLE.
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            DOut <= '0;
        end else if (last_bit) begin
            DOut <= shreg_shifted;
        end
    end

    // ------------------------------------------------------------------
    // Inter-bit gap timer: restarted on frame start and on every bit.
    // ------------------------------------------------------------------
    serial_word_loader_gap_timer #(
        .Timeout (Timeout)
    ) u_gap_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (frame_start || take_bit),
        .incr  (gap_idle),
        .tc    (gap_tc)
    );

endmodule : serial_word_loader

// File: tb/tb_serial_word_loader.sv
// ----------------------------------------------------------------------------
// tb_serial_word_loader
//   Directed bench for serial_word_loader (DataWidth=8, Timeout=4). Two
//   instances share the same stimulus: u_msb (MsbFirst=1) and u_lsb
//   (MsbFirst=0). Inputs are driven just after the rising edge; outputs are
//   observed 1 time unit after the active falling edge.
// ----------------------------------------------------------------------------
module tb_serial_word_loader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       SIn;
    logic       SValid;

    logic       ld_m, busy_m, done_m, err_m;
    logic [7:0] dout_m;
    logic       ld_l, busy_l, done_l, err_l;
    logic [7:0] dout_l;

    int n_cmp = 0;
    int n_mis = 0;

    // Per-test activity counters on u_msb, accumulated by step().
    int busy_cycles;
    int ld_lows;
    int done_pulses;
    int err_pulses;

    always #5 Clk = ~Clk;

    serial_word_loader #(.DataWidth(8), .MsbFirst(1'b1), .Timeout(4)) u_msb (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .SIn    (SIn),
        .SValid (SValid),
        .LD     (ld_m),
        .DOut   (dout_m),
        .Busy   (busy_m),
        .Done   (done_m),
        .Err    (err_m)
    );

    serial_word_loader #(.DataWidth(8), .MsbFirst(1'b0), .Timeout(4)) u_lsb (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .SIn    (SIn),
        .SValid (SValid),
        .LD     (ld_l),
        .DOut   (dout_l),
        .Busy   (busy_l),
        .Done   (done_l),
        .Err    (err_l)
    );

    // Apply one set of inputs, let one falling edge consume them, return
    // 1 time unit after that edge.
    task automatic step(input logic st, input logic b, input logic v);
        @(posedge Clk);
        #1;
        Start  = st;
        SIn    = b;
        SValid = v;
        @(negedge Clk);
        #1;
        if (busy_m) busy_cycles++;
        if (!ld_m)  ld_lows++;
        if (done_m) done_pulses++;
        if (err_m)  err_pulses++;
    endtask

    task automatic clear_counters();
        busy_cycles = 0;
        ld_lows     = 0;
        done_pulses = 0;
        err_pulses  = 0;
    endtask

    // Start a frame and send 8 bits, seq[7] first, with 'gap' idle cycles
    // between consecutive bits. Returns right after the 8th bit's edge.
    task automatic send_bits(input logic [7:0] seq, input int gap, input logic st_hold);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                repeat (gap) step(st_hold, 1'b0, 1'b0);
            end
            step(st_hold, seq[7-i], 1'b1);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; SIn = 1'b0; SValid = 1'b0;
        #2;
        n_cmp++;
        if ({ld_m, busy_m, done_m, err_m} !== 4'b1000) begin
            n_mis++;
            $display("FAIL reset_ctrl: got LD/Busy/Done/Err=%b want 1000", {ld_m, busy_m, done_m, err_m});
        end
        n_cmp++;
        if (dout_m !== 8'h00) begin
            n_mis++;
            $display("FAIL reset_dout: got %h want 00", dout_m);
        end
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    // Frame A5, contiguous bits, MSB first.
    task automatic test_basic_frame();
        clear_counters();
        send_bits(8'hA5, 0, 1'b0);
        n_cmp++;
        if ({ld_m, done_m, busy_m} !== 3'b011) begin
            n_mis++;
            $display("FAIL basic_strobe: got LD/Done/Busy=%b want 011", {ld_m, done_m, busy_m});
        end
        n_cmp++;
        if (dout_m !== 8'hA5) begin
            n_mis++;
            $display("FAIL basic_dout: got %h want a5", dout_m);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({ld_m, done_m, busy_m} !== 3'b100) begin
            n_mis++;
            $display("FAIL basic_after: got LD/Done/Busy=%b want 100", {ld_m, done_m, busy_m});
        end
        n_cmp++;
        if (busy_cycles !== 9) begin
            n_mis++;
            $display("FAIL basic_busy_len: got %0d want 9", busy_cycles);
        end
        n_cmp++;
        if (ld_lows !== 1 || done_pulses !== 1 || err_pulses !== 0) begin
            n_mis++;
            $display("FAIL basic_pulses: got ld_low=%0d done=%0d err=%0d want 1 1 0",
                     ld_lows, done_pulses, err_pulses);
        end
    endtask

    // Same stream 1,1,0,0,0,0,0,0 into both bit orders.
    task automatic test_bit_order();
        send_bits(8'b1100_0000, 0, 1'b0);
        n_cmp++;
        if (dout_m !== 8'hC0) begin
            n_mis++;
            $display("FAIL order_msb: got %h want c0", dout_m);
        end
        n_cmp++;
        if (dout_l !== 8'h03) begin
            n_mis++;
            $display("FAIL order_lsb: got %h want 03", dout_l);
        end
        n_cmp++;
        if (ld_l !== 1'b0) begin
            n_mis++;
            $display("FAIL order_lsb_ld: got %b want 0", ld_l);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Frame 5A with 3 idle cycles between bits: just under the timeout.
    task automatic test_max_gap();
        clear_counters();
        send_bits(8'h5A, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dout_m !== 8'h5A) begin
            n_mis++;
            $display("FAIL gap_dout: got %h want 5a", dout_m);
        end
        n_cmp++;
        if (err_pulses !== 0 || ld_lows !== 1) begin
            n_mis++;
            $display("FAIL gap_pulses: got err=%0d ld_low=%0d want 0 1", err_pulses, ld_lows);
        end
        // start + 8 bits + 7*3 gap cycles
        n_cmp++;
        if (busy_cycles !== 30) begin
            n_mis++;
            $display("FAIL gap_busy_len: got %0d want 30", busy_cycles);
        end
    endtask

    // After A5 is loaded: 3 bits then 4 idle cycles -> abort.
    task automatic test_timeout();
        send_bits(8'hA5, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        clear_counters();
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({err_m, busy_m} !== 2'b01) begin
            n_mis++;
            $display("FAIL tmo_early: got Err/Busy=%b want 01", {err_m, busy_m});
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({err_m, ld_m, done_m, busy_m} !== 4'b1101) begin
            n_mis++;
            $display("FAIL tmo_err: got Err/LD/Done/Busy=%b want 1101", {err_m, ld_m, done_m, busy_m});
        end
        n_cmp++;
        if (dout_m !== 8'hA5) begin
            n_mis++;
            $display("FAIL tmo_dout_hold: got %h want a5", dout_m);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({err_m, busy_m} !== 2'b00) begin
            n_mis++;
            $display("FAIL tmo_after: got Err/Busy=%b want 00", {err_m, busy_m});
        end
        n_cmp++;
        if (ld_lows !== 0 || err_pulses !== 1) begin
            n_mis++;
            $display("FAIL tmo_pulses: got ld_low=%0d err=%0d want 0 1", ld_lows, err_pulses);
        end
    endtask

    // Asynchronous reset in the middle of a frame, then a clean frame.
    task automatic test_mid_frame_reset();
        clear_counters();
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b1);
        #2 Reset = 1'b1;
        #1;
        n_cmp++;
        if ({ld_m, busy_m, done_m, err_m} !== 4'b1000 || dout_m !== 8'h00) begin
            n_mis++;
            $display("FAIL rst_async: got LD/Busy/Done/Err=%b DOut=%h want 1000 00",
                     {ld_m, busy_m, done_m, err_m}, dout_m);
        end
        @(negedge Clk);
        #1;
        n_cmp++;
        if (busy_m !== 1'b0 || dout_m !== 8'h00) begin
            n_mis++;
            $display("FAIL rst_hold: got Busy=%b DOut=%h want 0 00", busy_m, dout_m);
        end
        @(posedge Clk);
        #1 Reset = 1'b0;
        n_cmp++;
        if (ld_lows !== 0) begin
            n_mis++;
            $display("FAIL rst_no_ld: got ld_low=%0d want 0", ld_lows);
        end
        send_bits(8'h3C, 0, 1'b0);
        n_cmp++;
        if (dout_m !== 8'h3C || ld_m !== 1'b0) begin
            n_mis++;
            $display("FAIL rst_reload: got DOut=%h LD=%b want 3c 0", dout_m, ld_m);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Start held high throughout; SValid pulses while IDLE.
    task automatic test_back_to_back();
        repeat (3) step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (busy_m !== 1'b0 || dout_m !== 8'h3C) begin
            n_mis++;
            $display("FAIL b2b_idle_valid: got Busy=%b DOut=%h want 0 3c", busy_m, dout_m);
        end
        clear_counters();
        send_bits(8'h0F, 0, 1'b1);
        n_cmp++;
        if (dout_m !== 8'h0F || dout_l !== 8'hF0) begin
            n_mis++;
            $display("FAIL b2b_first: got msb=%h lsb=%h want 0f f0", dout_m, dout_l);
        end
        // LOAD cycle: Start and SValid high, must be ignored.
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (busy_m !== 1'b0 || ld_m !== 1'b1) begin
            n_mis++;
            $display("FAIL b2b_gap: got Busy=%b LD=%b want 0 1", busy_m, ld_m);
        end
        // Second frame begins with this IDLE sample of Start.
        step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (busy_m !== 1'b1) begin
            n_mis++;
            $display("FAIL b2b_restart: got Busy=%b want 1", busy_m);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0 || i == 7) ? 1'b1 : 1'b0, 1'b1);
        end
        n_cmp++;
        if (dout_m !== 8'h81 || ld_m !== 1'b0) begin
            n_mis++;
            $display("FAIL b2b_second: got DOut=%h LD=%b want 81 0", dout_m, ld_m);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ld_lows !== 2 || done_pulses !== 2 || busy_cycles !== 18) begin
            n_mis++;
            $display("FAIL b2b_counts: got ld_low=%0d done=%0d busy=%0d want 2 2 18",
                     ld_lows, done_pulses, busy_cycles);
        end
    endtask

    initial begin
        clear_counters();
        test_reset();
        test_basic_frame();
        test_bit_order();
        test_max_gap();
        test_timeout();
        test_mid_frame_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_word_loader
